// File: rtl/dbus_req_slice.sv
`timescale 1ns/1ps
// dbus_req_slice
// One-deep registered slice between the MMU's translated data-bus request and
// the dcache/CBus. The request payload is captured into registers so the cache
// never sees the translation lookup combinationally. At most one request is
// outstanding; the addr_ok/data_ok handshake is tracked by a small FSM, load
// data is returned upstream from a register, and responses that belong to a
// request killed by a flush after the cache accepted it are drained silently.
module dbus_req_slice #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    // upstream (MMU side)
    input  logic             up_valid,
    input  logic [31:0]      up_addr,
    input  logic [2:0]       up_size,
    input  logic [3:0]       up_strobe,
    input  logic [31:0]      up_data,
    output logic             up_data_ok,
    output logic [31:0]      up_rdata,
    input  logic             flush,
    // downstream (dcache side)
    output logic             dn_valid,
    output logic [31:0]      dn_addr,
    output logic [2:0]       dn_size,
    output logic [3:0]       dn_strobe,
    output logic [31:0]      dn_data,
    input  logic             dn_addr_ok,
    input  logic             dn_data_ok,
    input  logic [31:0]      dn_rdata,
    // status / perf
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             after_resp_q, after_resp_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic [3:0]       strobe_q, strobe_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             accept;
    logic             capture;
    logic             stalling;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus the accept/capture strobes that steer the datapath
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The cycle right after a response still carries the
                // upstream's stale valid for the request just completed.
                if (up_valid && !flush && !after_resp_q) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    if (!dn_addr_ok) begin
                        // cache never saw it: drop without side effects
                        state_d = S_IDLE;
                    end else if (dn_data_ok) begin
                        // accepted and completed in the same cycle: nothing owed
                        state_d = S_IDLE;
                    end else begin
                        // accepted but data still owed by the cache
                        state_d = S_DRAIN;
                    end
                end else if (dn_addr_ok) begin
                    if (dn_data_ok) begin
                        capture = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dn_data_ok) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (dn_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Remember that the previous cycle was the response cycle
    always_comb begin
        after_resp_d = (state_q == S_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            after_resp_q <= 1'b0;
        end else begin
            after_resp_q <= after_resp_d;
        end
    end

    // Request payload: loaded only when a request is accepted, held otherwise
    always_comb begin
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        if (accept) begin
            addr_d   = up_addr;
            size_d   = up_size;
            strobe_d = up_strobe;
            wdata_d  = up_data;
        end
    end

    // Payload registers feeding the cache
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    // Read data: captured on the data phase of a live request only
    always_comb begin
        rdata_d = rdata_q;
        if (capture) begin
            rdata_d = dn_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Saturating count of cycles spent waiting on the cache (REQ or WAIT)
    always_comb begin
        stalling = (state_q == S_REQ) || (state_q == S_WAIT);
        stall_d  = stall_q;
        if (stalling && !(&stall_q)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // Outputs are decoded directly from registers; only up_data_ok also
    // looks at flush so a response racing an exception is never delivered.
    assign dn_valid   = (state_q == S_REQ);
    assign dn_addr    = addr_q;
    assign dn_size    = size_q;
    assign dn_strobe  = strobe_q;
    assign dn_data    = wdata_q;
    assign up_data_ok = (state_q == S_RESP) && !flush;
    assign up_rdata   = rdata_q;
    assign busy       = (state_q != S_IDLE);
    assign stall_cnt  = stall_q;

    // The cache may only complete a data phase while something is owed to it;
    // anything else is ignored by the FSM but flagged here.
    a_data_ok_in_phase : assert property (
        @(posedge clk) disable iff (reset)
        dn_data_ok |-> (state_q == S_REQ || state_q == S_WAIT || state_q == S_DRAIN)
    );

    // The payload presented to the cache must not move while dn_valid is high.
    a_payload_stable : assert property (
        @(posedge clk) disable iff (reset)
        (state_q == S_REQ && state_d == S_REQ) |-> !accept
    );

endmodule

// File: tb/tb_dbus_req_slice.sv
`timescale 1ns/1ps
// Self-checking bench for dbus_req_slice. Each transaction is described by
// its handshake timing (addr_ok delay, data_ok delay, flush cycle); expected
// per-cycle outputs are computed from that timeline with plain arithmetic.
module tb_dbus_req_slice;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             up_valid;
    logic [31:0]      up_addr;
    logic [2:0]       up_size;
    logic [3:0]       up_strobe;
    logic [31:0]      up_data;
    logic             up_data_ok;
    logic [31:0]      up_rdata;
    logic             flush;
    logic             dn_valid;
    logic [31:0]      dn_addr;
    logic [2:0]       dn_size;
    logic [3:0]       dn_strobe;
    logic [31:0]      dn_data;
    logic             dn_addr_ok;
    logic             dn_data_ok;
    logic [31:0]      dn_rdata;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] stall_model = '0;

    always #5 clk = ~clk;

    dbus_req_slice #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .up_valid   (up_valid),
        .up_addr    (up_addr),
        .up_size    (up_size),
        .up_strobe  (up_strobe),
        .up_data    (up_data),
        .up_data_ok (up_data_ok),
        .up_rdata   (up_rdata),
        .flush      (flush),
        .dn_valid   (dn_valid),
        .dn_addr    (dn_addr),
        .dn_size    (dn_size),
        .dn_strobe  (dn_strobe),
        .dn_data    (dn_data),
        .dn_addr_ok (dn_addr_ok),
        .dn_data_ok (dn_data_ok),
        .dn_rdata   (dn_rdata),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    task automatic idle_inputs();
        up_valid   = 1'b0;
        up_addr    = '0;
        up_size    = '0;
        up_strobe  = '0;
        up_data    = '0;
        flush      = 1'b0;
        dn_addr_ok = 1'b0;
        dn_data_ok = 1'b0;
        dn_rdata   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stall_model = '0;
    endtask

    // One request. Cycle 0 = IDLE cycle presenting up_valid. addr_ok is given
    // in REQ cycle A+1, data_ok D cycles later; f = flush cycle (-1 = none).
    task automatic run_txn(input string name, input logic [31:0] addr,
                           input logic [2:0] size, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int a_dly, input int d_dly, input int f,
                           input bit poke);
        int     t_a, t_d, e, lim_v, incr, hold_end;
        bit     killed, pulse, via_resp, drain_c, poke_eff;
        logic   exp_dv, exp_busy, exp_ok;
        longint s;
        t_a = a_dly + 1;
        t_d = a_dly + 1 + d_dly;
        killed = (f >= 0) && (f < t_a);
        if (f < 0) begin
            e = t_d + 2; pulse = 1; via_resp = 1; incr = t_d;
        end else if (f < t_a) begin
            e = f + 1;   pulse = 0; via_resp = 0; incr = f;
        end else if (f <= t_d) begin
            e = t_d + 1; pulse = 0; via_resp = 0; incr = f;
        end else begin
            e = t_d + 2; pulse = 0; via_resp = 1; incr = t_d;
        end
        lim_v    = killed ? f : t_a;
        hold_end = (f < 0) ? t_d + 1 : f - 1;
        poke_eff = poke && via_resp;
        $display("txn %s addr=%08h strb=%h addr_ok@%0d data_ok@%0d flush@%0d poke=%0b",
                 name, addr, strb, t_a, t_d, f, poke_eff);
        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            drain_c    = !killed && (f >= 0) && (c > f) && (c < e);
            up_valid   = (c <= hold_end) || drain_c || (poke_eff && c == e);
            up_addr    = drain_c ? ~addr : addr;
            up_size    = size;
            up_strobe  = strb;
            up_data    = drain_c ? ~wdata : wdata;
            flush      = (c == f);
            dn_addr_ok = !killed && (c == t_a);
            dn_data_ok = !killed && (c == t_d);
            dn_rdata   = (c == t_d) ? rdata : $urandom();
            #1;
            exp_dv   = (c >= 1) && (c <= lim_v);
            exp_busy = (c >= 1) && (c <= e - 1);
            exp_ok   = pulse && (c == t_d + 1);
            n_cmp++;
            if (dn_valid !== exp_dv) begin
                n_bad++;
                $display("FAIL %s c%0d dn_valid got %0b want %0b", name, c, dn_valid, exp_dv);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL %s c%0d busy got %0b want %0b", name, c, busy, exp_busy);
            end
            n_cmp++;
            if (up_data_ok !== exp_ok) begin
                n_bad++;
                $display("FAIL %s c%0d up_data_ok got %0b want %0b", name, c, up_data_ok, exp_ok);
            end
            if (exp_dv) begin
                n_cmp++;
                if ({dn_addr, dn_size, dn_strobe, dn_data} !== {addr, size, strb, wdata}) begin
                    n_bad++;
                    $display("FAIL %s c%0d dn_payload got %08h/%0d/%h/%08h want %08h/%0d/%h/%08h",
                             name, c, dn_addr, dn_size, dn_strobe, dn_data, addr, size, strb, wdata);
                end
            end
            if (exp_ok && strb == 4'h0) begin
                n_cmp++;
                if (up_rdata !== rdata) begin
                    n_bad++;
                    $display("FAIL %s c%0d up_rdata got %08h want %08h", name, c, up_rdata, rdata);
                end
            end
            if (c == e) begin
                s = longint'(stall_model) + incr;
                stall_model = (s > longint'({CNT_W{1'b1}})) ? '1 : s[CNT_W-1:0];
                n_cmp++;
                if (stall_cnt !== stall_model) begin
                    n_bad++;
                    $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, stall_model);
                end
            end
        end
        if (poke_eff) begin
            // stale valid in the cycle after the response must not start a request
            @(negedge clk);
            idle_inputs();
            #1;
            n_cmp++;
            if (dn_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s post_resp_accept got dn_valid=%0b busy=%0b want 0/0",
                         name, dn_valid, busy);
            end
        end else begin
            @(negedge clk);
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({dn_valid, up_data_ok, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 000", {dn_valid, up_data_ok, busy});
        end
        n_cmp++;
        if ({dn_addr, dn_size, dn_strobe, dn_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_payload got %08h/%0d/%h/%08h want zeros", dn_addr, dn_size, dn_strobe, dn_data);
        end
        n_cmp++;
        if (up_rdata !== 32'h0 || stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata_cnt got %08h/%0d want 0/0", up_rdata, stall_cnt);
        end
        reset = 1'b0;
        stall_model = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || dn_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release got busy=%0b dn_valid=%0b want 0/0", busy, dn_valid);
        end
    endtask

    task automatic test_load();
        run_txn("load", 32'h8000_0010, 3'd2, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, 1'b0);
    endtask

    task automatic test_store();
        do_reset();
        run_txn("store", 32'h8000_0100, 3'd2, 4'b0011, 32'h1234_5678, 32'h0, 2, 2, -1, 1'b0);
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL store_stall_cnt got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_flush_req();
        run_txn("flush_req", 32'h0000_0200, 3'd2, 4'h0, 32'h0, 32'h1111_2222, 3, 1, 2, 1'b0);
    endtask

    task automatic test_flush_wait();
        run_txn("flush_wait", 32'h0000_0300, 3'd2, 4'h0, 32'h0, 32'h3333_4444, 0, 5, 2, 1'b0);
        run_txn("after_drain", 32'h0000_0304, 3'd2, 4'h0, 32'h0, 32'h5555_6666, 1, 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 32'h0000_0000, 3'd2, 4'h0, 32'h0, 32'hAAAA_0000, 0, 1, -1, 1'b1);
        run_txn("b2b_4", 32'h0000_0004, 3'd2, 4'h0, 32'h0, 32'hBBBB_0004, 0, 0, -1, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        $display("txn reset_in_wait addr=a5a50000");
        @(negedge clk);
        up_valid = 1'b1; up_addr = 32'hA5A5_0000; up_size = 3'd2;
        up_strobe = 4'h0; up_data = 32'h0;
        @(negedge clk);
        dn_addr_ok = 1'b1;
        @(negedge clk);
        dn_addr_ok = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || dn_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_pre got busy=%0b dn_valid=%0b want 1/0", busy, dn_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({dn_valid, up_data_ok, busy} !== 3'b000 || stall_cnt !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_ctrl got %b cnt=%0d want 000 cnt=0", {dn_valid, up_data_ok, busy}, stall_cnt);
        end
        n_cmp++;
        if ({dn_addr, dn_size, dn_strobe, dn_data, up_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_data got %08h/%0d/%h/%08h/%08h want zeros",
                     dn_addr, dn_size, dn_strobe, dn_data, up_rdata);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        stall_model = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_release got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_flush_idle();
        $display("txn flush_idle addr=00000400");
        @(negedge clk);
        up_valid = 1'b1; up_addr = 32'h0000_0400; flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (dn_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle got dn_valid=%0b busy=%0b want 0/0", dn_valid, busy);
        end
        run_txn("post_flush_idle", 32'h0000_0408, 3'd1, 4'h0, 32'h0, 32'h0BAD_F00D, 0, 2, -1, 1'b0);
    endtask

    task automatic test_random();
        int a_dly, d_dly, f;
        logic [3:0] strb;
        for (int i = 0; i < 40; i++) begin
            a_dly = $urandom_range(0, 3);
            d_dly = $urandom_range(0, 3);
            f     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, a_dly + d_dly + 2) : -1;
            strb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn("rand", $urandom(), 3'($urandom_range(0, 2)), strb, $urandom(), $urandom(),
                    a_dly, d_dly, f, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_store();
        test_flush_req();
        test_flush_wait();
        test_back_to_back();
        test_reset_in_wait();
        test_flush_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
